adc_responder: RTL and testbench

- Synthesizable model of the parallel 8-bit ADC that sits on the far side of the PWM controller's conversion interface. It sees convStart, busy, rd_cs and adcVoltage from the ADC's side.
- Accepts a conversion request on convStart and holds busy high for a programmable conversion time. It then latches a sample from sample_in and presents it on adcVoltage while rd_cs is low.
- Used for on-chip loopback and closed-loop regulation testing without an external ADC.
- Inputs come from the slowed-clock domain, so they are resynchronized into clk.

---
 rtl/adc_responder.sv | 89 ++++++++
 tb/tb_adc_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// Behavioural stand-in for a parallel 8-bit ADC: a convStart edge starts a fixed-length
// conversion, and the captured sample is presented on a registered read port gated by rd_cs.
module adc_responder #(
  parameter int DATA_W      = 8,
  parameter int CONV_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              convStart,
  input  logic              rd_cs,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic [DATA_W-1:0] adcVoltage,
  output logic              data_oe,
  output logic              data_fresh,
  output logic [3:0]        overrun_cnt
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, rd_sync;
  logic                   cs_s, rd_s, cs_prev, rd_prev;
  logic                   rise, rd_end;
  logic [7:0]             cnt;
  logic [DATA_W-1:0]      hold, result;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign rise   = cs_s & ~cs_prev;
  assign rd_end = rd_s & ~rd_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cs_sync     <= '0;
      rd_sync     <= '0;
      cs_prev     <= 1'b0;
      rd_prev     <= 1'b0;
      cnt         <= '0;
      hold        <= '0;
      result      <= '0;
      busy        <= 1'b0;
      adcVoltage  <= '0;
      data_oe     <= 1'b0;
      data_fresh  <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], convStart};
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], rd_cs};
      cs_prev    <= cs_s;
      rd_prev    <= rd_s;
      data_oe    <= 1'b0;
      adcVoltage <= '0;
      // Clear comes first so a completing conversion below can override it.
      if (rd_end && state == IDLE && data_oe)
        data_fresh <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            hold  <= sample_in;
            cnt   <= 8'(CONV_CYCLES - 1);
            busy  <= 1'b1;
            state <= CONVERT;
          end else if (!rd_s) begin
            // A starting conversion suppresses the read so data_oe and busy never overlap.
            data_oe    <= 1'b1;
            adcVoltage <= result;
          end
        end
        CONVERT: begin
          if (rise && overrun_cnt != 4'hf)
            overrun_cnt <= overrun_cnt + 4'd1;
          if (cnt == 8'd0) begin
            result     <= hold;
            data_fresh <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench: converted values are queued at request time and compared on read-out.
module tb_adc_responder;
  localparam int CONV = 16;

  logic       clk = 1'b0;
  logic       reset, convStart, rd_cs, convStart1, rd_cs1;
  logic [7:0] sample_in;
  logic       busy, data_oe, data_fresh, busy1, data_oe1, data_fresh1;
  logic [7:0] adcVoltage, adcVoltage1;
  logic [3:0] overrun_cnt, overrun_cnt1;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];
  logic [7:0] q1[$];
  logic [7:0] last, last1;

  always #5 clk = ~clk;

  adc_responder #(.DATA_W(8), .CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .convStart(convStart), .rd_cs(rd_cs), .sample_in(sample_in),
    .busy(busy), .adcVoltage(adcVoltage), .data_oe(data_oe), .data_fresh(data_fresh),
    .overrun_cnt(overrun_cnt));

  adc_responder #(.DATA_W(8), .CONV_CYCLES(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .convStart(convStart1), .rd_cs(rd_cs1), .sample_in(sample_in),
    .busy(busy1), .adcVoltage(adcVoltage1), .data_oe(data_oe1), .data_fresh(data_fresh1),
    .overrun_cnt(overrun_cnt1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request a conversion of val; post replaces sample_in one clk after capture, np extra
  // requests are pulsed during the window, abort_at >= 0 asserts reset at that cycle.
  task automatic start_conv(input logic [7:0] val, input logic [7:0] post,
                            input int np, input int abort_at);
    int lat, width, i;
    logic oe_busy;
    sample_in = val;
    convStart = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin step(1); lat++; end
    chk("start_lat", lat, 3);
    width = 0; i = 0; oe_busy = 1'b0;
    while (busy && i < 300) begin
      width++;
      if (data_oe) oe_busy = 1'b1;
      if (i == 0) sample_in = post;
      convStart = ((i % 2) == 1) && (i < 2 * np);
      if (i == abort_at) reset = 1'b0;
      step(1);
      i++;
    end
    convStart = 1'b0;
    chk("oe_during_busy", oe_busy, 0);
    if (reset) begin
      chk("busy_width", width, CONV);
      chk("fresh_set", data_fresh, 1);
      q.push_back(val);
    end
  endtask

  task automatic do_read();
    int lat;
    rd_cs = 1'b0;
    lat = 0;
    while (!data_oe && lat < 10) begin step(1); lat++; end
    chk("rd_lat", lat, 3);
    while (q.size() > 0) last = q.pop_front();
    chk("rd_data", adcVoltage, last);
    rd_cs = 1'b1;
    step(5);
    chk("rd_oe_off", data_oe, 0);
    chk("rd_adc_off", adcVoltage, 0);
    chk("rd_fresh_clr", data_fresh, 0);
  endtask

  initial begin
    logic [7:0] bh;
    int lat;
    reset = 1'b0; convStart = 1'b0; rd_cs = 1'b1; sample_in = '0;
    convStart1 = 1'b0; rd_cs1 = 1'b1;
    last = '0; last1 = '0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_adc", adcVoltage, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_fresh", data_fresh, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_busy1", busy1, 0);
    reset = 1'b1;
    step(6);

    // basic conversion and read
    start_conv(8'hA5, 8'hA5, 0, -1);
    do_read();

    // sample changes after capture are ignored; re-read returns same value
    start_conv(8'hC3, 8'h3C, 0, -1);
    do_read();
    do_read();

    // overrun pulses: conversions continue, counter saturates
    start_conv(8'h10, 8'h10, 6, -1);
    chk("ovr_6", overrun_cnt, 6);
    start_conv(8'h20, 8'h20, 6, -1);
    chk("ovr_12", overrun_cnt, 12);
    start_conv(8'h30, 8'h30, 6, -1);
    chk("ovr_sat", overrun_cnt, 15);
    do_read();

    // read held low through a conversion
    rd_cs = 1'b0;
    step(6);
    start_conv(8'h66, 8'h66, 0, -1);
    step(1);
    while (q.size() > 0) last = q.pop_front();
    chk("hold_rd_oe", data_oe, 1);
    chk("hold_rd_data", adcVoltage, last);
    rd_cs = 1'b1;
    step(5);
    chk("hold_rd_fresh", data_fresh, 0);

    // reset mid-conversion
    start_conv(8'h11, 8'h11, 0, -1);
    start_conv(8'h77, 8'h77, 0, 7);
    chk("abort_busy", busy, 0);
    chk("abort_adc", adcVoltage, 0);
    chk("abort_fresh", data_fresh, 0);
    chk("abort_ovr", overrun_cnt, 0);
    q.delete(); last = '0;
    step(1);
    reset = 1'b1;
    step(6);
    do_read();
    start_conv(8'h5A, 8'h5A, 0, -1);
    do_read();

    // single-cycle conversions, back-to-back requests
    bh = '0;
    convStart1 = 1'b1; sample_in = 8'h21; q1.push_back(8'h21);
    step(1); bh[1] = busy1; convStart1 = 1'b0;
    step(1); bh[2] = busy1; convStart1 = 1'b1;
    step(1); bh[3] = busy1; convStart1 = 1'b0; sample_in = 8'h42; q1.push_back(8'h42);
    for (int j = 4; j < 8; j++) begin step(1); bh[j] = busy1; end
    chk("b2b_busy", bh, 8'b0010_1000);
    chk("b2b_ovr", overrun_cnt1, 0);
    step(10);
    chk("b2b_fresh", data_fresh1, 1);
    rd_cs1 = 1'b0;
    lat = 0;
    while (!data_oe1 && lat < 10) begin step(1); lat++; end
    chk("b2b_rd_lat", lat, 3);
    while (q1.size() > 0) last1 = q1.pop_front();
    chk("b2b_data", adcVoltage1, last1);
    rd_cs1 = 1'b1;
    step(5);
    chk("b2b_fresh_clr", data_fresh1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
